// File: rtl/clause_scheduler.sv
// Clause scheduler: walks the clause list once per sweep, fetching each
// clause from coefficient memory, loading it into the clause register and
// handing it to the evaluator, while accumulating sweep results.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_start; result outputs hold the last sweep
// FETCH | memory read strobe for the clause at the current index
// LOAD  | read data valid; strobe the clause register write enable
// EVAL  | evaluation requested; wait for in_eval_done
// DONE  | one-cycle end-of-sweep pulse
module clause_scheduler #(
  parameter int NUMBER_OF_CLAUSES  = 4,
  parameter int CLAUSE_INDEX_WIDTH = 2,
  parameter int COUNT_WIDTH        = 3,
  parameter bit STOP_ON_UNSAT      = 1'b0
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic                          in_start,
  input  logic                          in_abort,
  input  logic                          in_eval_done,
  input  logic                          in_clause_satisfied,
  output logic                          out_mem_read_enable,
  output logic [CLAUSE_INDEX_WIDTH-1:0] out_clause_address,
  output logic                          out_write_enable,
  output logic                          out_eval_valid,
  output logic                          out_busy,
  output logic                          out_done,
  output logic                          out_all_satisfied,
  output logic [COUNT_WIDTH-1:0]        out_satisfied_count,
  output logic [CLAUSE_INDEX_WIDTH-1:0] out_first_unsat_index
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CLAUSE_INDEX_WIDTH-1:0] LAST_INDEX =
    CLAUSE_INDEX_WIDTH'(NUMBER_OF_CLAUSES - 1);

  state_t                        state;
  logic [CLAUSE_INDEX_WIDTH-1:0] index;
  logic                          unsat_seen;
  logic                          last_clause;
  logic                          stop_now;

  // The memory address is the index itself; the index only moves on the
  // EVAL to FETCH edge, so it is stable for the whole clause.
  assign out_clause_address = index;
  assign last_clause        = (index == LAST_INDEX);
  assign stop_now           = STOP_ON_UNSAT && !in_clause_satisfied;

  // Sequencer with registered strobes: each strobe is set on the edge that
  // enters its state and dropped on the edge that leaves it.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state                 <= IDLE;
      index                 <= '0;
      unsat_seen            <= 1'b0;
      out_mem_read_enable   <= 1'b0;
      out_write_enable      <= 1'b0;
      out_eval_valid        <= 1'b0;
      out_busy              <= 1'b0;
      out_done              <= 1'b0;
      out_all_satisfied     <= 1'b0;
      out_satisfied_count   <= '0;
      out_first_unsat_index <= '0;
    end else begin
      out_mem_read_enable <= 1'b0;
      out_write_enable    <= 1'b0;
      out_done            <= 1'b0;

      case (state)
        IDLE: begin
          // Start wins over a simultaneous abort; abort means nothing here.
          if (in_start) begin
            state                 <= FETCH;
            index                 <= '0;
            unsat_seen            <= 1'b0;
            out_all_satisfied     <= 1'b1;
            out_satisfied_count   <= '0;
            out_first_unsat_index <= '0;
            out_mem_read_enable   <= 1'b1;
            out_busy              <= 1'b1;
          end
        end

        FETCH: begin
          if (in_abort) begin
            state    <= IDLE;
            out_busy <= 1'b0;
          end else begin
            // Memory read latency is one cycle, so data is ready in LOAD.
            state            <= LOAD;
            out_write_enable <= 1'b1;
          end
        end

        LOAD: begin
          if (in_abort) begin
            state    <= IDLE;
            out_busy <= 1'b0;
          end else begin
            state          <= EVAL;
            out_eval_valid <= 1'b1;
          end
        end

        EVAL: begin
          // Abort beats a same-cycle eval_done: the result is discarded.
          if (in_abort) begin
            state          <= IDLE;
            out_eval_valid <= 1'b0;
            out_busy       <= 1'b0;
          end else if (in_eval_done) begin
            out_eval_valid <= 1'b0;
            if (in_clause_satisfied) begin
              out_satisfied_count <= out_satisfied_count + COUNT_WIDTH'(1);
            end else begin
              out_all_satisfied <= 1'b0;
              if (!unsat_seen) begin
                unsat_seen            <= 1'b1;
                out_first_unsat_index <= index;
              end
            end
            if (!last_clause && !stop_now) begin
              state               <= FETCH;
              index               <= index + CLAUSE_INDEX_WIDTH'(1);
              out_mem_read_enable <= 1'b1;
            end else begin
              state    <= DONE;
              out_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          out_eval_valid <= 1'b0;
          out_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_scheduler.sv
// Bench for clause_scheduler: a behavioural evaluator answers each clause,
// a queue holds the address stream each sweep is expected to issue, and
// each scenario task checks the sweep results it expects.
module tb_clause_scheduler;

  logic in_clk = 1'b0;
  logic in_reset, in_start, in_abort, in_eval_done, in_clause_satisfied;

  logic       rd0, we0, ev0, busy0, done0, alls0;
  logic [1:0] addr0, fu0;
  logic [2:0] cnt0;
  logic       rd1, we1, ev1, busy1, done1, alls1;
  logic [1:0] addr1, fu1;
  logic [2:0] cnt1;

  logic       rd, we, ev, busy, done, alls;
  logic [1:0] addr, fu;
  logic [2:0] cnt;
  bit         sel;

  int vectors     = 0;
  int miscompares = 0;
  int exp_addr[$];
  int latency;
  int write_pulses;
  int eval_cycles[4];
  bit done_seen, done_after, busy_after;

  always #5 in_clk = ~in_clk;

  clause_scheduler #(
    .NUMBER_OF_CLAUSES(4), .CLAUSE_INDEX_WIDTH(2), .COUNT_WIDTH(3), .STOP_ON_UNSAT(1'b0)
  ) dut0 (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
    .in_eval_done(in_eval_done), .in_clause_satisfied(in_clause_satisfied),
    .out_mem_read_enable(rd0), .out_clause_address(addr0), .out_write_enable(we0),
    .out_eval_valid(ev0), .out_busy(busy0), .out_done(done0),
    .out_all_satisfied(alls0), .out_satisfied_count(cnt0), .out_first_unsat_index(fu0)
  );

  clause_scheduler #(
    .NUMBER_OF_CLAUSES(4), .CLAUSE_INDEX_WIDTH(2), .COUNT_WIDTH(3), .STOP_ON_UNSAT(1'b1)
  ) dut1 (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
    .in_eval_done(in_eval_done), .in_clause_satisfied(in_clause_satisfied),
    .out_mem_read_enable(rd1), .out_clause_address(addr1), .out_write_enable(we1),
    .out_eval_valid(ev1), .out_busy(busy1), .out_done(done1),
    .out_all_satisfied(alls1), .out_satisfied_count(cnt1), .out_first_unsat_index(fu1)
  );

  // Select which instance the evaluator model is talking to.
  always_comb begin
    if (sel) begin
      rd = rd1; we = we1; ev = ev1; busy = busy1; done = done1; alls = alls1;
      addr = addr1; fu = fu1; cnt = cnt1;
    end else begin
      rd = rd0; we = we0; ev = ev0; busy = busy0; done = done0; alls = alls0;
      addr = addr0; fu = fu0; cnt = cnt0;
    end
  end

  task automatic do_reset();
    @(negedge in_clk);
    in_reset = 1'b1;
    in_start = 1'b0; in_abort = 1'b0; in_eval_done = 1'b0; in_clause_satisfied = 1'b0;
    @(negedge in_clk);
    in_reset = 1'b0;
  endtask

  // Runs one sweep against the selected instance. Expected addresses are
  // queued up front from the clause results and the planned interruption;
  // every read strobe pops one and checks it.
  task automatic run_sweep(input bit hold_start, input logic [3:0] sat,
                           input int stall_clause, input int stall_cycles,
                           input int abort_clause, input int reset_clause);
    int cyc, waited, e;
    bit fin, prev_rd, aborting;
    exp_addr.delete();
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(i);
      if (i == abort_clause || i == reset_clause) break;
      if (sel && !sat[i]) break;
    end
    latency = -1; done_seen = 0; done_after = 0; busy_after = 1; write_pulses = 0;
    for (int i = 0; i < 4; i++) eval_cycles[i] = 0;
    waited = 0; prev_rd = 0; aborting = 0; fin = 0; cyc = 0;

    @(negedge in_clk);
    in_start = 1'b1;
    while (!fin && cyc < 100) begin
      @(negedge in_clk);
      cyc++;
      if (!hold_start) in_start = 1'b0;
      in_eval_done = 1'b0; in_abort = 1'b0; in_clause_satisfied = 1'b0;
      if (aborting) begin
        busy_after = busy;
        fin = 1;
      end else begin
        if (rd) begin
          vectors++;
          if (exp_addr.size() == 0) begin
            miscompares++;
            $display("FAIL addr_extra: address %0d issued, no further address expected", addr);
          end else begin
            e = exp_addr.pop_front();
            if (addr !== 2'(e)) begin
              miscompares++;
              $display("FAIL addr_order: address %0d, expected %0d", addr, e);
            end
          end
        end
        if (prev_rd || we) begin
          vectors++;
          if (we !== prev_rd) begin
            miscompares++;
            $display("FAIL we_timing: write_enable %0b, expected %0b (cycle %0d)", we, prev_rd, cyc);
          end
        end
        if (we) write_pulses++;
        prev_rd = rd;
        if (done) begin
          latency = cyc;
          done_seen = 1;
          fin = 1;
        end else if (we && addr == 2'(reset_clause) && reset_clause >= 0) begin
          #1 in_reset = 1'b1;
          #1;
          vectors++;
          if ({rd, we, ev, busy, done, alls, cnt, fu} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_async: outputs %b, expected all zero", {rd, we, ev, busy, done, alls, cnt, fu});
          end
          fin = 1;
        end else if (ev) begin
          eval_cycles[addr]++;
          if (int'(addr) == stall_clause && waited < stall_cycles) begin
            waited++;
          end else begin
            in_eval_done = 1'b1;
            in_clause_satisfied = sat[addr];
            if (int'(addr) == abort_clause) begin
              in_abort = 1'b1;
              in_start = 1'b0;
              aborting = 1;
            end
          end
        end
      end
    end
    in_start = 1'b0; in_abort = 1'b0; in_eval_done = 1'b0; in_clause_satisfied = 1'b0;
    if (!fin) begin
      miscompares++;
      $display("FAIL sweep_timeout: no end of sweep within 100 cycles");
    end
    if (done_seen) begin
      @(negedge in_clk);
      done_after = done;
      busy_after = busy;
    end
    vectors++;
    if (exp_addr.size() != 0) begin
      miscompares++;
      $display("FAIL addr_missing: %0d expected addresses never issued", exp_addr.size());
    end
  endtask

  task automatic test_reset();
    in_reset = 1'b1;
    in_start = 1'b0; in_abort = 1'b0; in_eval_done = 1'b0; in_clause_satisfied = 1'b0;
    @(negedge in_clk);
    vectors++;
    if ({rd0, addr0, we0, ev0, busy0, done0, alls0, cnt0, fu0} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: outputs %b, expected all zero", {rd0, addr0, we0, ev0, busy0, done0, alls0, cnt0, fu0});
    end
    vectors++;
    if ({rd1, addr1, we1, ev1, busy1, done1, alls1, cnt1, fu1} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: outputs %b, expected all zero", {rd1, addr1, we1, ev1, busy1, done1, alls1, cnt1, fu1});
    end
    in_reset = 1'b0;
    // Eval_done outside EVAL must not disturb an idle machine.
    @(negedge in_clk);
    in_eval_done = 1'b1; in_clause_satisfied = 1'b1;
    @(negedge in_clk);
    in_eval_done = 1'b0; in_clause_satisfied = 1'b0;
    vectors++;
    if ({busy0, done0, cnt0} !== 5'd0) begin
      miscompares++;
      $display("FAIL idle_eval_done: busy/done/count %b, expected 00000", {busy0, done0, cnt0});
    end
  endtask

  task automatic test_full_pass();
    sel = 0;
    do_reset();
    run_sweep(0, 4'b1111, -1, 0, -1, -1);
    vectors++;
    if (latency !== 13) begin miscompares++; $display("FAIL full_latency: %0d, expected 13", latency); end
    vectors++;
    if (cnt !== 3'd4) begin miscompares++; $display("FAIL full_count: %0d, expected 4", cnt); end
    vectors++;
    if (alls !== 1'b1 || fu !== 2'd0) begin
      miscompares++;
      $display("FAIL full_flags: all_sat %0b first_unsat %0d, expected 1 and 0", alls, fu);
    end
    vectors++;
    if (write_pulses !== 4) begin miscompares++; $display("FAIL full_writes: %0d, expected 4", write_pulses); end
    vectors++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_pulse: done %0b busy %0b after DONE, expected 0 0", done_after, busy_after);
    end
    // Results must hold while idle.
    repeat (3) @(negedge in_clk);
    vectors++;
    if (cnt !== 3'd4 || alls !== 1'b1) begin
      miscompares++;
      $display("FAIL full_hold: count %0d all_sat %0b, expected 4 and 1", cnt, alls);
    end
  endtask

  task automatic test_mixed();
    sel = 0;
    do_reset();
    run_sweep(0, 4'b0101, -1, 0, -1, -1);
    vectors++;
    if (latency !== 13) begin miscompares++; $display("FAIL mixed_latency: %0d, expected 13", latency); end
    vectors++;
    if (cnt !== 3'd2) begin miscompares++; $display("FAIL mixed_count: %0d, expected 2", cnt); end
    vectors++;
    if (alls !== 1'b0) begin miscompares++; $display("FAIL mixed_all_sat: %0b, expected 0", alls); end
    vectors++;
    if (fu !== 2'd1) begin miscompares++; $display("FAIL mixed_first_unsat: %0d, expected 1", fu); end
  endtask

  task automatic test_early_stop();
    sel = 1;
    do_reset();
    run_sweep(0, 4'b1011, -1, 0, -1, -1);
    vectors++;
    if (latency !== 10) begin miscompares++; $display("FAIL stop_latency: %0d, expected 10", latency); end
    vectors++;
    if (cnt !== 3'd2) begin miscompares++; $display("FAIL stop_count: %0d, expected 2", cnt); end
    vectors++;
    if (fu !== 2'd2 || alls !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_flags: first_unsat %0d all_sat %0b, expected 2 and 0", fu, alls);
    end
    sel = 0;
  endtask

  task automatic test_stall();
    sel = 0;
    do_reset();
    run_sweep(0, 4'b1111, 0, 5, -1, -1);
    vectors++;
    if (eval_cycles[0] !== 6) begin miscompares++; $display("FAIL stall_eval_valid: %0d cycles, expected 6", eval_cycles[0]); end
    vectors++;
    if (latency !== 18) begin miscompares++; $display("FAIL stall_latency: %0d, expected 18", latency); end
    vectors++;
    if (cnt !== 3'd4) begin miscompares++; $display("FAIL stall_count: %0d, expected 4", cnt); end
  endtask

  task automatic test_abort();
    bit late_done;
    sel = 0;
    do_reset();
    run_sweep(1, 4'b1111, -1, 0, 1, -1);
    vectors++;
    if (busy_after !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy %0b, expected 0", busy_after); end
    vectors++;
    if (done_seen !== 1'b0) begin miscompares++; $display("FAIL abort_done: done seen %0b, expected 0", done_seen); end
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge in_clk);
      if (done || busy) late_done = 1;
    end
    vectors++;
    if (late_done !== 1'b0) begin miscompares++; $display("FAIL abort_quiet: activity %0b after abort, expected 0", late_done); end
    vectors++;
    if (cnt !== 3'd1 || alls !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_partial: count %0d all_sat %0b, expected 1 and 1", cnt, alls);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit strobe;
    sel = 0;
    do_reset();
    run_sweep(0, 4'b1111, -1, 0, -1, 2);
    @(negedge in_clk);
    in_reset = 1'b0;
    strobe = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      if (done || we || rd) strobe = 1;
    end
    vectors++;
    if (strobe !== 1'b0) begin miscompares++; $display("FAIL reset_quiet: strobe %0b after release, expected 0", strobe); end
    run_sweep(0, 4'b1111, -1, 0, -1, -1);
    vectors++;
    if (latency !== 13 || cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_rerun: latency %0d count %0d, expected 13 and 4", latency, cnt);
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_full_pass();
    test_mixed();
    test_early_stop();
    test_stall();
    test_abort();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
